// File: rtl/agex_hazard_ctrl_pkg.sv
// Shared constants for the AGEX hazard/redirect controller.
package agex_hazard_ctrl_pkg;

    // Register index width for the 32-entry architectural register file.
    localparam int REGNO_W = 5;

    // Default width of each per-register in-flight write counter.
    localparam int HZ_CNT_W = 2;

    // Default PC / branch target width.
    localparam int HZ_DBITS = 32;

    // Redirect FSM state codes. REDIRECT is reserved and behaves like IDLE.
    localparam logic [1:0] HZ_IDLE     = 2'b00;
    localparam logic [1:0] HZ_REDIRECT = 2'b01;
    localparam logic [1:0] HZ_DRAIN    = 2'b10;

endpackage

// File: rtl/agex_hazard_ctrl_reg_scoreboard.sv
// Per-register in-flight write counters. A register is busy while any write
// issued from DE has not yet retired in WB. Counter overflow or underflow
// raises a sticky error; x0 never counts.
module agex_hazard_ctrl_reg_scoreboard
    import agex_hazard_ctrl_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = HZ_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_valid,
    input  logic [REGNO_W-1:0] inc_idx,
    input  logic               dec_valid,
    input  logic [REGNO_W-1:0] dec_idx,
    output logic [NREGS-1:0]   busy,
    output logic               err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [NREGS-1:0] err_hit;
    logic             err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 is hardwired: never busy, never flags an error.
                assign busy[gi]    = 1'b0;
                assign err_hit[gi] = 1'b0;
            end else begin : g_cnt
                logic             inc_hit;
                logic             dec_hit;
                logic             bad_op;
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;

                assign inc_hit = inc_valid && (inc_idx == REGNO_W'(gi));
                assign dec_hit = dec_valid && (dec_idx == REGNO_W'(gi));

                // Next count: simultaneous inc/dec cancel; saturate and flag on misuse.
                always_comb begin
                    cnt_next = cnt_reg;
                    bad_op   = 1'b0;
                    if (inc_hit && !dec_hit) begin
                        if (cnt_reg == CNT_MAX) bad_op = 1'b1;
                        else                    cnt_next = cnt_reg + CNT_ONE;
                    end else if (dec_hit && !inc_hit) begin
                        if (cnt_reg == CNT_ZERO) bad_op = 1'b1;
                        else                     cnt_next = cnt_reg - CNT_ONE;
                    end
                end

                // Counter register.
                always_ff @(posedge clk) begin
                    if (reset) cnt_reg <= '0;
                    else       cnt_reg <= cnt_next;
                end

                assign busy[gi]    = (cnt_reg != CNT_ZERO);
                assign err_hit[gi] = bad_op;
            end
        end
    endgenerate

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)         err_reg <= 1'b0;
        else if (|err_hit) err_reg <= 1'b1;
    end

    assign err = err_reg;

endmodule

// File: rtl/agex_hazard_ctrl.sv
// Hazard and redirect controller for the FE-DE-AGEX-MEM-WB pipeline.
// Stalls DE on RAW hazards against in-flight writes and redirects FE on taken
// branches resolved in AGEX, squashing wrong-path work for 1+FLUSH_DEPTH cycles.
module agex_hazard_ctrl
    import agex_hazard_ctrl_pkg::*;
#(
    parameter int NREGS       = 32,
    parameter int CNT_W       = HZ_CNT_W,
    parameter int FLUSH_DEPTH = 1,
    parameter int DBITS       = HZ_DBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               de_valid,
    input  logic [REGNO_W-1:0] de_rs1,
    input  logic               de_rs1_used,
    input  logic [REGNO_W-1:0] de_rs2,
    input  logic               de_rs2_used,
    input  logic [REGNO_W-1:0] de_rd,
    input  logic               de_wr_reg,
    input  logic               agex_br_valid,
    input  logic               agex_br_taken,
    input  logic [DBITS-1:0]   agex_br_target,
    input  logic               wb_valid,
    input  logic [REGNO_W-1:0] wb_rd,
    input  logic               wb_wr_reg,
    output logic               stall_fe,
    output logic               stall_de,
    output logic               flush_de,
    output logic               redirect_valid,
    output logic [DBITS-1:0]   redirect_pc,
    output logic               sb_error
);

    localparam logic [2:0] DRAIN_LOAD = 3'(FLUSH_DEPTH);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [2:0]       drain_cnt_reg;
    logic [2:0]       drain_cnt_next;
    logic             take;
    logic             raw;
    logic             de_fire;
    logic             sb_inc;
    logic             sb_dec;
    logic [NREGS-1:0] busy;

    // Busy is sampled before this cycle's WB decrement: the regfile has no
    // write-through, so a reader waits one extra cycle after retirement.
    agex_hazard_ctrl_reg_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .inc_valid (sb_inc),
        .inc_idx   (de_rd),
        .dec_valid (sb_dec),
        .dec_idx   (wb_rd),
        .busy      (busy),
        .err       (sb_error)
    );

    // Redirect FSM next-state; branches are ignored while draining because
    // AGEX only holds bubbles then.
    always_comb begin
        state_next     = HZ_IDLE;
        drain_cnt_next = 3'd0;
        take           = 1'b0;
        case (state_reg)
            HZ_DRAIN: begin
                if (drain_cnt_reg > 3'd1) begin
                    state_next     = HZ_DRAIN;
                    drain_cnt_next = drain_cnt_reg - 3'd1;
                end
            end
            default: begin
                take = agex_br_valid & agex_br_taken;
                if (take && (FLUSH_DEPTH > 0)) begin
                    state_next     = HZ_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= HZ_IDLE;
            drain_cnt_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Stall/flush/redirect outputs; a flush always overrides a RAW stall.
    always_comb begin
        raw            = de_valid & ((de_rs1_used & busy[de_rs1]) |
                                     (de_rs2_used & busy[de_rs2]));
        flush_de       = take | (state_reg == HZ_DRAIN);
        stall_de       = raw & ~flush_de;
        stall_fe       = stall_de;
        redirect_valid = take;
        redirect_pc    = take ? agex_br_target : '0;
        de_fire        = de_valid & ~stall_de & ~flush_de;
        sb_inc         = de_fire & de_wr_reg & (de_rd != '0);
        sb_dec         = wb_valid & wb_wr_reg & (wb_rd != '0);
    end

endmodule

// File: tb/tb_agex_hazard_ctrl.sv
// Self-checking bench for agex_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a per-register in-flight count model.
module tb_agex_hazard_ctrl;

    localparam int FD = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic        de_rs1_used;
    logic [4:0]  de_rs2;
    logic        de_rs2_used;
    logic [4:0]  de_rd;
    logic        de_wr_reg;
    logic        agex_br_valid;
    logic        agex_br_taken;
    logic [31:0] agex_br_target;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wr_reg;
    logic        stall_fe;
    logic        stall_de;
    logic        flush_de;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        sb_error;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding writes per register, squash cycles left, error flag.
    int inflight[32];
    int squash_left;
    bit err_m;

    always #5 clk = ~clk;

    agex_hazard_ctrl #(
        .NREGS       (32),
        .CNT_W       (2),
        .FLUSH_DEPTH (FD),
        .DBITS       (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .de_valid       (de_valid),
        .de_rs1         (de_rs1),
        .de_rs1_used    (de_rs1_used),
        .de_rs2         (de_rs2),
        .de_rs2_used    (de_rs2_used),
        .de_rd          (de_rd),
        .de_wr_reg      (de_wr_reg),
        .agex_br_valid  (agex_br_valid),
        .agex_br_taken  (agex_br_taken),
        .agex_br_target (agex_br_target),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_wr_reg      (wb_wr_reg),
        .stall_fe       (stall_fe),
        .stall_de       (stall_de),
        .flush_de       (flush_de),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .sb_error       (sb_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < 32; r++) inflight[r] = 0;
        squash_left = 0;
        err_m       = 1'b0;
    endtask

    task automatic idle_inputs();
        de_valid = 0; de_rs1 = 0; de_rs1_used = 0; de_rs2 = 0; de_rs2_used = 0;
        de_rd = 0; de_wr_reg = 0; agex_br_valid = 0; agex_br_taken = 0;
        agex_br_target = 0; wb_valid = 0; wb_rd = 0; wb_wr_reg = 0;
    endtask

    task automatic set_de(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit wr);
        de_valid = v; de_rs1 = 5'(rs1); de_rs1_used = u1; de_rs2 = 5'(rs2);
        de_rs2_used = u2; de_rd = 5'(rd); de_wr_reg = wr;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle(input string tag);
        bit take, busy1, busy2, raw, flush, stall, fire, inc, dec;
        int nxt_squash;
        @(negedge clk);
        take  = (squash_left == 0) && agex_br_valid && agex_br_taken;
        busy1 = (de_rs1 != 0) && (inflight[de_rs1] > 0);
        busy2 = (de_rs2 != 0) && (inflight[de_rs2] > 0);
        raw   = de_valid && ((de_rs1_used && busy1) || (de_rs2_used && busy2));
        flush = take || (squash_left > 0);
        stall = raw && !flush;
        fire  = de_valid && !stall && !flush;
        chk({tag, ".stall_de"}, 32'(stall_de), 32'(stall));
        chk({tag, ".stall_fe"}, 32'(stall_fe), 32'(stall));
        chk({tag, ".flush_de"}, 32'(flush_de), 32'(flush));
        chk({tag, ".redir_v"}, 32'(redirect_valid), 32'(take));
        chk({tag, ".redir_pc"}, redirect_pc, take ? agex_br_target : 32'd0);
        chk({tag, ".sb_error"}, 32'(sb_error), 32'(err_m));
        $display("%0t %s st=%0b fl=%0b rv=%0b pc=%0h err=%0b", $time, tag,
                 stall_de, flush_de, redirect_valid, redirect_pc, sb_error);
        inc = fire && de_wr_reg && (de_rd != 0);
        dec = wb_valid && wb_wr_reg && (wb_rd != 0);
        nxt_squash = take ? FD : ((squash_left > 0) ? squash_left - 1 : 0);
        @(posedge clk);
        if (reset) begin
            clear_model();
        end else begin
            squash_left = nxt_squash;
            if (!(inc && dec && de_rd == wb_rd)) begin
                if (inc) begin
                    if (inflight[de_rd] == 3) err_m = 1'b1;
                    else inflight[de_rd]++;
                end
                if (dec) begin
                    if (inflight[wb_rd] == 0) err_m = 1'b1;
                    else inflight[wb_rd]--;
                end
            end
        end
        #1;
    endtask

    initial begin
        int r;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;

        // Idle after reset: everything quiet.
        repeat (10) cycle("idle");

        // ADD x5, then a reader of x5 stalls until WB retires x5, plus one cycle.
        set_de(1, 1, 1, 2, 1, 5, 1);
        cycle("add_x5");
        set_de(1, 5, 1, 0, 0, 6, 1);
        repeat (3) cycle("raw_x5");
        wb_valid = 1; wb_rd = 5; wb_wr_reg = 1;
        cycle("wb_x5");
        wb_valid = 0; wb_wr_reg = 0;
        cycle("raw_fire");
        wb_valid = 1; wb_rd = 6; wb_wr_reg = 1; de_valid = 0;
        cycle("wb_x6");
        idle_inputs();

        // Write x0 then read x0: never a stall.
        set_de(1, 0, 0, 0, 0, 0, 1);
        cycle("wr_x0");
        set_de(1, 0, 1, 0, 1, 3, 0);
        repeat (2) cycle("rd_x0");
        idle_inputs();

        // Taken branch: squashed DE write to x9 must not mark x9 busy.
        agex_br_valid = 1; agex_br_taken = 1; agex_br_target = 32'h100;
        set_de(1, 0, 0, 0, 0, 9, 1);
        cycle("br_take");
        agex_br_valid = 0; agex_br_taken = 0; agex_br_target = 0;
        cycle("br_drain");
        set_de(1, 9, 1, 9, 1, 0, 0);
        repeat (2) cycle("rd_x9");
        idle_inputs();

        // Not-taken branch: no effect.
        agex_br_valid = 1; agex_br_taken = 0; agex_br_target = 32'h200;
        cycle("br_nt");
        idle_inputs();

        // Taken branch while DE is RAW-stalled: flush wins; older x5 write retires.
        set_de(1, 0, 0, 0, 0, 5, 1);
        cycle("wr_x5");
        set_de(1, 0, 0, 5, 1, 4, 1);
        cycle("stall_x5");
        agex_br_valid = 1; agex_br_taken = 1; agex_br_target = 32'h3c0;
        cycle("br_vs_stall");
        agex_br_valid = 0; agex_br_taken = 0;
        cycle("drain_vs_stall");
        wb_valid = 1; wb_rd = 5; wb_wr_reg = 1;
        cycle("wb_x5b");
        wb_valid = 0; wb_wr_reg = 0;
        cycle("after_wb");
        idle_inputs();

        // Four writes to x7 without WB: the fourth overflows, error is sticky.
        set_de(1, 0, 0, 0, 0, 7, 1);
        repeat (4) cycle("wr_x7");
        idle_inputs();
        repeat (2) cycle("err_sticky");

        // Reset in the middle of the drain window.
        agex_br_valid = 1; agex_br_taken = 1; agex_br_target = 32'h44;
        cycle("br_pre_rst");
        idle_inputs();
        reset = 1'b1;
        cycle("rst_drain");
        reset = 1'b0;
        set_de(1, 7, 1, 0, 0, 0, 0);
        repeat (3) cycle("post_rst");
        idle_inputs();

        // Randomized traffic over a small register window to force hazards.
        for (int i = 0; i < 400; i++) begin
            reset = (i % 60 == 59);
            set_de($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1));
            agex_br_valid  = ($urandom_range(0, 5) == 0);
            agex_br_taken  = $urandom_range(0, 1);
            agex_br_target = $urandom & 32'hffff_fffc;
            r = $urandom_range(0, 3);
            wb_rd     = 5'(r);
            wb_wr_reg = $urandom_range(0, 7) != 0;
            wb_valid  = (inflight[r] > 0) ? ($urandom_range(0, 1) == 1)
                                          : ($urandom_range(0, 40) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
